// File: rtl/mag_bin_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mag_bin_sequencer
//  Purpose  : Streams signed FFT bins into per-bin L1 magnitudes |re|+|im|,
//             sharing one external abs unit between the two operands.
//  Revision : 1.0  initial release
// ============================================================================
module mag_bin_sequencer #(
    parameter int DATA_W   = 8,
    parameter int NUM_BINS = 64,
    parameter int BIN_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic [DATA_W-1:0] abs_operand,
    input  logic [DATA_W-1:0] abs_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_mag,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_sof,
    output logic              frame_err
);

    localparam logic [BIN_W-1:0] c_lastBin = BIN_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABS_RE = 2'd1,
        S_ABS_IM = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [DATA_W-1:0]   r_reQ;
    logic [DATA_W-1:0]   r_imQ;
    logic                r_lastQ;
    logic [DATA_W:0]     r_acc;
    logic [DATA_W:0]     r_outMag;
    logic [BIN_W-1:0]    r_outBin;
    logic [BIN_W-1:0]    r_binCnt;
    logic                r_frameErr;

    logic                w_inReady;
    logic                w_outValid;
    logic [DATA_W-1:0]   w_absOperand;
    logic                w_capture;
    logic                w_handshake;
    logic                w_lastBin;
    logic [DATA_W:0]     w_sum;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and per-state outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState  = r_state;
        w_absOperand = '0;
        w_inReady    = 1'b0;
        w_outValid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_inReady = 1'b1;
                if (in_valid) begin
                    w_nextState = S_ABS_RE;
                end
            end
            S_ABS_RE: begin
                w_absOperand = r_reQ;
                w_nextState  = S_ABS_IM;
            end
            S_ABS_IM: begin
                w_absOperand = r_imQ;
                w_nextState  = S_OUT;
            end
            S_OUT: begin
                w_outValid = 1'b1;
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_capture   = (r_state == S_IDLE) && in_valid;
    assign w_handshake = w_outValid && out_ready;
    assign w_lastBin   = (r_binCnt == c_lastBin);
    // abs_result is unsigned, so the most negative sample still fits after zero-extension
    assign w_sum       = r_acc + {1'b0, abs_result};

    // ------------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reQ   <= '0;
            r_imQ   <= '0;
            r_lastQ <= 1'b0;
        end else if (w_capture) begin
            r_reQ   <= in_re;
            r_imQ   <= in_im;
            r_lastQ <= in_last;
        end
    end

    // ------------------------------------------------------------------------
    // Magnitude accumulation and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_outMag <= '0;
            r_outBin <= '0;
        end else begin
            if (r_state == S_ABS_RE) begin
                r_acc <= {1'b0, abs_result};
            end
            if (r_state == S_ABS_IM) begin
                r_outMag <= w_sum;
                r_outBin <= r_binCnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bin counter and framing check, both resolved on the output handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_binCnt   <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= 1'b0;
            if (w_handshake) begin
                // Either an early or a missing last resynchronises the column to bin 0
                r_frameErr <= r_lastQ ^ w_lastBin;
                if (r_lastQ || w_lastBin) begin
                    r_binCnt <= '0;
                end else begin
                    r_binCnt <= r_binCnt + BIN_W'(1);
                end
            end
        end
    end

    assign in_ready    = w_inReady & rst_n;
    assign abs_operand = w_absOperand;
    assign out_valid   = w_outValid;
    assign out_mag     = r_outMag;
    assign out_bin     = r_outBin;
    assign out_sof     = w_outValid && (r_outBin == '0);
    assign frame_err   = r_frameErr;

endmodule
`default_nettype wire

// File: tb/tb_mag_bin_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mag_bin_sequencer
//  Purpose  : Scoreboard bench for mag_bin_sequencer with an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mag_bin_sequencer;

    localparam int c_dataW   = 8;
    localparam int c_numBins = 64;
    localparam int c_binW    = 6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [c_dataW-1:0]  in_re = '0;
    logic [c_dataW-1:0]  in_im = '0;
    logic                in_last = 1'b0;
    logic [c_dataW-1:0]  abs_operand;
    logic [c_dataW-1:0]  abs_result;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [c_dataW:0]    out_mag;
    logic [c_binW-1:0]   out_bin;
    logic                out_sof;
    logic                frame_err;

    mag_bin_sequencer #(
        .DATA_W  (c_dataW),
        .NUM_BINS(c_numBins),
        .BIN_W   (c_binW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .abs_operand(abs_operand),
        .abs_result (abs_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mag    (out_mag),
        .out_bin    (out_bin),
        .out_sof    (out_sof),
        .frame_err  (frame_err)
    );

    // Shared abs unit: signed in, unsigned out, combinational
    assign abs_result = abs_operand[c_dataW-1] ? c_dataW'(-abs_operand) : abs_operand;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mag;
        int bin;
        bit sof;
        bit err;
        int acceptCyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mBin = 0;
    int   stallLeft = 0;
    bit   randReady = 1'b0;

    function automatic void chk(string nm, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: magnitude by plain arithmetic, bin position by frame rules
    task automatic sendBin(input int re, input int im, input bit last);
        int   n;
        exp_t e;
        n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("inReadyTimeout", 0, 1);
            return;
        end
        in_re    = c_dataW'(re);
        in_im    = c_dataW'(im);
        in_last  = last;
        in_valid = 1'b1;
        e.mag       = iabs(re) + iabs(im);
        e.bin       = mBin;
        e.sof       = (mBin == 0);
        e.err       = last != (mBin == c_numBins - 1);
        e.acceptCyc = cyc;
        q.push_back(e);
        mBin = (last || mBin == c_numBins - 1) ? 0 : mBin + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Downstream ready driver
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else if (randReady) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: compares presented outputs against the scoreboard head
    bit curSeen = 1'b0;
    bit errExp  = 1'b0;
    bit prevHs  = 1'b0;
    initial begin
        bit   hs;
        bit   errNext;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                curSeen = 1'b0;
                errExp  = 1'b0;
                prevHs  = 1'b0;
            end else begin
                chk("frameErr", frame_err, errExp);
                if (prevHs) chk("inReadyAfterHs", in_ready, 1);
                hs      = out_valid && out_ready;
                errNext = 1'b0;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpectedOutput", 1, 0);
                    end else begin
                        e = q[0];
                        if (!curSeen) begin
                            chk("latency", cyc, e.acceptCyc + 3);
                            curSeen = 1'b1;
                        end
                        chk("outMag", out_mag, e.mag);
                        chk("outBin", out_bin, e.bin);
                        chk("outSof", out_sof, e.sof);
                        chk("inReadyInOut", in_ready, 0);
                        if (hs) begin
                            errNext = e.err;
                            void'(q.pop_front());
                            curSeen = 1'b0;
                        end
                    end
                end else if (curSeen) begin
                    chk("validDropped", out_valid, 1);
                    curSeen = 1'b0;
                end
                errExp = errNext;
                prevHs = hs;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        chk({tag, "_inReady"}, in_ready, 0);
        chk({tag, "_outValid"}, out_valid, 0);
        chk({tag, "_outMag"}, out_mag, 0);
        chk({tag, "_outBin"}, out_bin, 0);
        chk({tag, "_outSof"}, out_sof, 0);
        chk({tag, "_frameErr"}, frame_err, 0);
        chk({tag, "_absOperand"}, abs_operand, 0);
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 checkResetValues("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("inReadyAfterRst", in_ready, 1);

        // Directed: abs operand sequencing and small magnitude
        sendBin(-3, 4, 1'b0);
        chk("absOpRe", $signed(abs_operand), -3);
        @(posedge clk);
        #1 chk("absOpIm", $signed(abs_operand), 4);

        // Extremes of the signed range
        sendBin(-128, -128, 1'b0);
        sendBin(0, 0, 1'b0);
        sendBin(127, -128, 1'b0);

        // Backpressure: five stalled cycles in OUT
        stallLeft = 5;
        sendBin(10, -20, 1'b0);

        // Early last on bin 10
        for (int i = 5; i <= 10; i++) sendBin(rnd(), rnd(), i == 10);

        // Full well-formed frame under random backpressure
        randReady = 1'b1;
        for (int i = 0; i < c_numBins; i++) sendBin(rnd(), rnd(), i == c_numBins - 1);

        // Frame with missing last
        for (int i = 0; i < c_numBins; i++) sendBin(rnd(), rnd(), 1'b0);

        // Reset during ABS_IM of bin 5
        randReady = 1'b0;
        for (int i = 0; i < 5; i++) sendBin(rnd(), rnd(), 1'b0);
        sendBin(55, -66, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        mBin = 0;
        #1 checkResetValues("midRst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sendBin(1, -2, 1'b0);
        sendBin(-7, 7, 1'b0);

        // Random tail with occasional early last
        randReady = 1'b1;
        for (int i = 0; i < 60; i++) sendBin(rnd(), rnd(), $urandom_range(0, 15) == 0);

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drained", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
